// File: rtl/stream_proc_seq.sv
// stream_proc_seq: FIFO-fed instruction sequencer with a 4-op ALU and accumulator.
// One instruction in flight; FETCH -> OP0 -> OP1 -> EXEC -> WRITE, stalling on empty/full FIFOs.
module stream_proc_seq #(
   parameter int DATA_WIDTH  = 4,
   parameter int INST_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   ctrl_empty,
   input  logic [INST_WIDTH-1:0]  ctrl_data,
   output logic                   ctrl_deq,
   input  logic                   int_empty,
   input  logic [DATA_WIDTH-1:0]  int_data,
   output logic                   int_deq,
   input  logic                   nin_empty,
   input  logic [DATA_WIDTH-1:0]  nin_data,
   output logic                   nin_deq,
   input  logic                   nout_full,
   output logic [DATA_WIDTH-1:0]  nout_data,
   output logic                   nout_enq,
   input  logic                   bus_full,
   output logic [DATA_WIDTH-1:0]  bus_data,
   output logic                   bus_enq,
   output logic                   busy,
   output logic [DATA_WIDTH-1:0]  acc,
   output logic                   carry,
   output logic [COUNT_WIDTH-1:0] inst_count
);
   typedef enum logic [2:0] {IDLE, FETCH, OP0, OP1, EXEC, WRITE} state_t;
   state_t state_q, state_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic [DATA_WIDTH-1:0] op0_q, op0_d, op1_q, op1_d, acc_q, acc_d;
   logic [DATA_WIDTH-1:0] nout_q, nout_d, bus_q, bus_d;
   logic carry_q, carry_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0] src;
   logic src_rdy, take, wr_ok;
   logic [DATA_WIDTH-1:0] src_val, res;
   logic [DATA_WIDTH:0] sum, diff;
   always_comb begin
      src     = (state_q == OP1) ? inst_q[3:2] : inst_q[5:4];
      src_rdy = (src == 2'd0) ? !int_empty : (src == 2'd1) ? !nin_empty : 1'b1;
      src_val = (src == 2'd0) ? int_data : (src == 2'd1) ? nin_data : (src == 2'd2) ? acc_q : '0;
      take    = ((state_q == OP0) || (state_q == OP1)) && src_rdy;
      sum     = {1'b0, op0_q} + {1'b0, op1_q};
      diff    = {1'b0, op0_q} - {1'b0, op1_q};
      res     = (inst_q[7:6] == 2'd0) ? sum[DATA_WIDTH-1:0] :
                (inst_q[7:6] == 2'd1) ? diff[DATA_WIDTH-1:0] :
                (inst_q[7:6] == 2'd2) ? (op0_q & op1_q) : (op0_q ^ op1_q);
      // a destination whose bit is clear never blocks retirement
      wr_ok   = (state_q == WRITE) && !(inst_q[1] && nout_full) && !(inst_q[0] && bus_full);
   end
   assign ctrl_deq   = (state_q == FETCH) && !ctrl_empty;
   assign int_deq    = take && (src == 2'd0);
   assign nin_deq    = take && (src == 2'd1);
   assign nout_enq   = wr_ok && inst_q[1];
   assign bus_enq    = wr_ok && inst_q[0];
   assign busy       = (state_q != IDLE);
   assign acc        = acc_q;
   assign carry      = carry_q;
   assign nout_data  = nout_q;
   assign bus_data   = bus_q;
   assign inst_count = cnt_q;
   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      op0_d   = op0_q;
      op1_d   = op1_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      nout_d  = nout_q;
      bus_d   = bus_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE:  if (enable && !ctrl_empty) state_d = FETCH;
         FETCH: if (!ctrl_empty) begin
            inst_d  = ctrl_data;
            state_d = OP0;
         end
         OP0:   if (src_rdy) begin
            op0_d   = src_val;
            state_d = OP1;
         end
         OP1:   if (src_rdy) begin
            op1_d   = src_val;
            state_d = EXEC;
         end
         EXEC:  begin
            acc_d   = res;
            nout_d  = res;
            bus_d   = res;
            carry_d = (inst_q[7:6] == 2'd0) ? sum[DATA_WIDTH] :
                      (inst_q[7:6] == 2'd1) ? diff[DATA_WIDTH] : carry_q;
            state_d = WRITE;
         end
         WRITE: if (wr_ok) begin
            cnt_d   = cnt_q + COUNT_WIDTH'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         inst_q  <= '0;
         op0_q   <= '0;
         op1_q   <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         nout_q  <= '0;
         bus_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         op0_q   <= op0_d;
         op1_q   <= op1_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         nout_q  <= nout_d;
         bus_q   <= bus_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_stream_proc_seq.sv
// tb_stream_proc_seq: queue-backed FIFO models around stream_proc_seq, checked against an
// instruction-level reference that evaluates each instruction as it leaves the control FIFO.
module tb_stream_proc_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset, enable, ctrl_empty, ctrl_deq, int_empty, int_deq, nin_empty, nin_deq;
   logic nout_full, nout_enq, bus_full, bus_enq, busy, carry;
   logic [7:0] ctrl_data;
   logic [3:0] int_data, nin_data, nout_data, bus_data, acc;
   logic [15:0] inst_count;
   stream_proc_seq dut (
      .clk(clk), .reset(reset), .enable(enable),
      .ctrl_empty(ctrl_empty), .ctrl_data(ctrl_data), .ctrl_deq(ctrl_deq),
      .int_empty(int_empty), .int_data(int_data), .int_deq(int_deq),
      .nin_empty(nin_empty), .nin_data(nin_data), .nin_deq(nin_deq),
      .nout_full(nout_full), .nout_data(nout_data), .nout_enq(nout_enq),
      .bus_full(bus_full), .bus_data(bus_data), .bus_enq(bus_enq),
      .busy(busy), .acc(acc), .carry(carry), .inst_count(inst_count)
   );
   logic [7:0] fc[$];
   logic [3:0] fi[$], fn[$], mi[$], mn[$], exp_n[$], exp_b[$];
   int n_vec = 0, n_err = 0, proto = 0, cyc = 0, last_n_cyc = 0;
   int n_ipop = 0, n_npop = 0, n_nenq = 0, n_benq = 0;
   int m_acc = 0, m_carry = 0, m_cnt = 0;
   bit hold_nin = 0, hold_bus = 0, rnd = 0, en_prev = 0, saw_both = 0, bus_enq_last = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic int opnd(input logic [1:0] s);
      if (s == 2'd0) return (mi.size() != 0) ? int'(mi.pop_front()) : 0;
      if (s == 2'd1) return (mn.size() != 0) ? int'(mn.pop_front()) : 0;
      return (s == 2'd2) ? m_acc : 0;
   endfunction
   task automatic model_exec(input logic [7:0] in);
      int a, b, r;
      a = opnd(in[5:4]);
      b = opnd(in[3:2]);
      case (in[7:6])
         2'd0: begin r = a + b; m_carry = (r > 15) ? 1 : 0; end
         2'd1: begin r = a - b + 16; m_carry = (a < b) ? 1 : 0; end
         2'd2: r = a & b;
         default: r = a ^ b;
      endcase
      r = r % 16;
      m_acc = r;
      if (in[1]) exp_n.push_back(4'(r));
      if (in[0]) exp_b.push_back(4'(r));
      m_cnt = (m_cnt + 1) % 65536;
   endtask
   task automatic drive_inputs();
      ctrl_empty = (fc.size() == 0);
      ctrl_data  = ctrl_empty ? 8'h00 : fc[0];
      int_empty  = (fi.size() == 0) || (rnd && $urandom_range(3) == 0);
      int_data   = (fi.size() == 0) ? 4'h0 : fi[0];
      nin_empty  = (fn.size() == 0) || hold_nin || (rnd && $urandom_range(3) == 0);
      nin_data   = (fn.size() == 0) ? 4'h0 : fn[0];
      nout_full  = rnd && $urandom_range(3) == 0;
      bus_full   = hold_bus || (rnd && $urandom_range(3) == 0);
      if (rnd) enable = ($urandom_range(2) != 0);
   endtask
   task automatic step();
      bit dc, di, dn;
      @(negedge clk);
      cyc++;
      if ((int_deq && int_empty) || (nin_deq && nin_empty) || (ctrl_deq && ctrl_empty)) proto++;
      if ((nout_enq && nout_full) || (bus_enq && bus_full) || (ctrl_deq && !en_prev)) proto++;
      if (ctrl_deq && !ctrl_empty) model_exec(fc[0]);
      en_prev = enable;
      dc = ctrl_deq; di = int_deq; dn = nin_deq;
      saw_both = saw_both || (nout_enq && bus_enq);
      bus_enq_last = bus_enq;
      if (nout_enq) begin
         n_nenq++;
         last_n_cyc = cyc;
         if (exp_n.size() == 0) chk("nout_extra_enq", 1, 0);
         else chk("nout_data", nout_data, exp_n.pop_front());
      end
      if (bus_enq) begin
         n_benq++;
         if (exp_b.size() == 0) chk("bus_extra_enq", 1, 0);
         else chk("bus_data", bus_data, exp_b.pop_front());
      end
      @(posedge clk);
      #1;
      if (dc && fc.size() != 0) void'(fc.pop_front());
      if (di && fi.size() != 0) begin void'(fi.pop_front()); n_ipop++; end
      if (dn && fn.size() != 0) begin void'(fn.pop_front()); n_npop++; end
      drive_inputs();
   endtask
   task automatic push_op(input bit to_nin, input logic [3:0] v);
      if (to_nin) begin fn.push_back(v); mn.push_back(v); end
      else begin fi.push_back(v); mi.push_back(v); end
   endtask
   task automatic issue(input logic [7:0] in);
      fc.push_back(in);
      drive_inputs();
   endtask
   task automatic wait_done(input string tag, input int bound);
      for (int k = 0; k < bound; k++) begin
         step();
         if (!busy && fc.size() == 0 && inst_count == 16'(m_cnt)) return;
      end
      chk({tag, "_timeout"}, 1, 0);
   endtask
   task automatic check_state(input string tag);
      chk({tag, "_acc"}, acc, 32'(m_acc));
      chk({tag, "_carry"}, carry, 32'(m_carry));
      chk({tag, "_cnt"}, inst_count, 32'(m_cnt));
      chk({tag, "_pending"}, exp_n.size() + exp_b.size(), 0);
   endtask
   initial begin
      int ip0, np0, c0, start;
      reset = 1'b0;
      enable = 1'b1;
      drive_inputs();
      repeat (3) step();
      chk("rst_busy", busy, 0);
      chk("rst_acc", acc, 0);
      chk("rst_carry", carry, 0);
      chk("rst_cnt", inst_count, 0);
      chk("rst_data", {nout_data, bus_data}, 0);
      chk("rst_strobes", {ctrl_deq, int_deq, nin_deq, nout_enq, bus_enq}, 0);
      reset = 1'b1;
      step();
      // ADD int,nin -> nout with no stalls
      push_op(0, 4'd3); push_op(1, 4'd5);
      start = cyc;
      issue(8'h06);
      wait_done("t1", 40);
      check_state("t1");
      chk("t1_acc_const", acc, 8);
      chk("t1_nout_enqs", n_nenq, 1);
      chk("t1_latency", last_n_cyc - start, 6);
      // ADD with carry out -> bus
      ip0 = n_ipop; np0 = n_npop;
      push_op(0, 4'd9); push_op(1, 4'd9);
      issue(8'h05);
      wait_done("t2", 40);
      check_state("t2");
      chk("t2_bus_data", bus_data, 2);
      chk("t2_carry", carry, 1);
      chk("t2_pops", {16'(n_ipop - ip0), 16'(n_npop - np0)}, 32'h0001_0001);
      // SUB with borrow -> both destinations in one cycle
      saw_both = 0;
      push_op(0, 4'd3); push_op(1, 4'd5);
      issue(8'h47);
      wait_done("t3", 40);
      check_state("t3");
      chk("t3_acc", acc, 4'hE);
      chk("t3_both_same_cycle", saw_both, 1);
      // same FIFO twice, then acc,acc
      ip0 = n_ipop;
      push_op(0, 4'd2); push_op(0, 4'd7);
      issue(8'h02);
      wait_done("t4a", 40);
      check_state("t4a");
      chk("t4_int_pops", n_ipop - ip0, 2);
      issue(8'hAA);
      wait_done("t4b", 40);
      check_state("t4b");
      chk("t4_and_acc", acc, 9);
      // bus backpressure held through WRITE
      hold_bus = 1;
      c0 = n_benq;
      push_op(0, 4'd1); push_op(1, 4'd2);
      issue(8'h05);
      repeat (15) step();
      chk("bf_no_enq", n_benq - c0, 0);
      chk("bf_busy", busy, 1);
      hold_bus = 0;
      drive_inputs();
      step();
      chk("bf_enq_next", bus_enq_last, 1);
      wait_done("bf", 40);
      check_state("bf");
      // nin empty while src0 waits on it
      hold_nin = 1;
      np0 = n_npop;
      c0 = m_cnt;
      push_op(1, 4'd4); push_op(0, 4'd1);
      issue(8'h11);
      repeat (8) step();
      chk("ne_no_deq", n_npop - np0, 0);
      chk("ne_busy", busy, 1);
      chk("ne_cnt_held", inst_count, 32'(c0));
      hold_nin = 0;
      wait_done("ne", 40);
      check_state("ne");
      chk("ne_result", bus_data, 5);
      // reset while parked in OP1
      hold_nin = 1;
      c0 = n_nenq + n_benq;
      push_op(0, 4'd6); push_op(1, 4'd1);
      issue(8'h06);
      repeat (6) step();
      chk("ro_busy", busy, 1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      fc.delete(); fi.delete(); fn.delete(); mi.delete(); mn.delete();
      exp_n.delete(); exp_b.delete();
      m_acc = 0; m_carry = 0; m_cnt = 0;
      hold_nin = 0;
      drive_inputs();
      step();
      chk("ro_idle", busy, 0);
      chk("ro_acc", acc, 0);
      chk("ro_cnt", inst_count, 0);
      chk("ro_no_enq", n_nenq + n_benq - c0, 0);
      // randomized instructions with random stalls and enable drops
      rnd = 1;
      for (int t = 0; t < 80; t++) begin
         logic [7:0] in;
         in = 8'($urandom);
         for (int k = 0; k < 2; k++) begin
            logic [1:0] s;
            s = (k == 0) ? in[5:4] : in[3:2];
            if (s < 2'd2) push_op(s[0], 4'($urandom));
         end
         if ($urandom_range(3) == 0) push_op($urandom_range(1) == 1, 4'($urandom));
         issue(in);
         wait_done("rnd", 400);
         check_state("rnd");
      end
      chk("protocol_violations", proto, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
